// File: rtl/volume_ctrl.sv
// Saturating volume controller with press-and-hold auto-repeat.
// Optional mute toggle is built only when VOL_MUTE_EN is defined.
module volume_ctrl #(
  parameter int VOL_W         = 3,
  parameter int VOL_MAX       = 7,
  parameter int VOL_INIT      = 3,
  parameter int AMP_W         = 16,
  parameter int AMP_STEP      = 4096,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_pulse,
  input  logic             down_pulse,
  input  logic             up_held,
  input  logic             down_held,
  input  logic             mute_pulse,
  output logic [VOL_W-1:0] vol_level,
  output logic [AMP_W-1:0] amp,
  output logic             vol_changed,
  output logic             at_max,
  output logic             at_min,
  output logic             muted,
  output logic [1:0]       dbg_state
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [VOL_W-1:0] LVL_MAX     = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] LVL_INIT    = VOL_W'(VOL_INIT);
  localparam logic [AMP_W-1:0] AMP_STEP_W  = AMP_W'(AMP_STEP);
  localparam logic [AMP_W-1:0] AMP_INIT    = AMP_W'(VOL_INIT * AMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_up;

  logic             both_pulse;
  logic             start_up;
  logic             start_dn;
  logic             start_any;
  logic             hold_alone;
  logic             cnt_hit;
  logic             auto_step;
  logic             step_up;
  logic             step_dn;
  logic [VOL_W-1:0] level_nxt;
  logic             changed_nxt;
  logic             muted_nxt;
  logic [AMP_W-1:0] amp_nxt;

  // A single pulse starts a new press unless it repeats the direction already held.
  always_comb begin
    both_pulse  = up_pulse & down_pulse;
    start_up    = up_pulse & ~down_pulse & ((state == S_IDLE) | ~dir_up);
    start_dn    = down_pulse & ~up_pulse & ((state == S_IDLE) | dir_up);
    start_any   = start_up | start_dn;
    hold_alone  = dir_up ? (up_held & ~down_held) : (down_held & ~up_held);
    cnt_hit     = (state == S_DELAY) ? (cnt == DELAY_LAST) : (cnt == PERIOD_LAST);
    auto_step   = (state != S_IDLE) & ~both_pulse & ~start_any & hold_alone & cnt_hit;
    step_up     = start_up | (auto_step & dir_up);
    step_dn     = start_dn | (auto_step & ~dir_up);
    level_nxt   = vol_level;
    changed_nxt = 1'b0;
    if (step_up && (vol_level != LVL_MAX)) begin
      level_nxt   = vol_level + VOL_W'(1);
      changed_nxt = 1'b1;
    end else if (step_dn && (vol_level != '0)) begin
      level_nxt   = vol_level - VOL_W'(1);
      changed_nxt = 1'b1;
    end
    amp_nxt = muted_nxt ? '0 : (AMP_W'(level_nxt) * AMP_STEP_W);
  end

`ifdef VOL_MUTE_EN
  assign muted_nxt = muted ^ mute_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) muted <= 1'b0;
    else        muted <= muted_nxt;
  end
`else
  logic unused_mute_pulse;
  assign unused_mute_pulse = mute_pulse;
  assign muted_nxt         = 1'b0;
  assign muted             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dir_up      <= 1'b1;
      vol_level   <= LVL_INIT;
      amp         <= AMP_INIT;
      vol_changed <= 1'b0;
    end else begin
      vol_level   <= level_nxt;
      amp         <= amp_nxt;
      vol_changed <= changed_nxt;
      if (start_any) begin
        state  <= S_DELAY;
        cnt    <= '0;
        dir_up <= start_up;
      end else if (state != S_IDLE) begin
        if (both_pulse || !hold_alone) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else if (cnt_hit) begin
          state <= S_REPEAT;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign at_max    = (vol_level == LVL_MAX);
  assign at_min    = (vol_level == '0);
  assign dbg_state = state;

endmodule
